uart_rx_fifo_writer: RTL

//   Upstream producer for the 8-bit sync FIFO: deserialises an async UART line (8 data bits,
//   LSB first, optional even parity, 1 stop bit) and writes each good byte into the FIFO.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx_fifo_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: FSM state encoding and the byte type.
// Latency: none (types only).
// Backpressure: none (types only).
package uart_rx_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a parameterised reset value.
// Latency: 2 clk cycles.
// Backpressure: none; the output follows the input continuously.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// UART receiver (8N1 / 8E1) that writes each good byte into a downstream FIFO.
// Latency: result registered one cycle after the mid-stop-bit sample (plus 2-cycle rx sync).
// Backpressure: none to the line; a full FIFO drops the byte and pulses overrun.
module uart_rx_fifo_writer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rx,
    input  logic  fifo_full,
    output logic  fifo_wr,
    output byte_t fifo_data,
    output logic  busy,
    output logic  frame_err,
    output logic  parity_err,
    output logic  overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    logic rx_s;

    rx_state_t     state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [2:0]    bit_idx_d, bit_idx_q;
    byte_t         shreg_d, shreg_q;
    logic          par_bad_d, par_bad_q;
    logic          brk_d, brk_q;
    logic          fifo_wr_d, fifo_wr_q;
    byte_t         fifo_data_d, fifo_data_q;
    logic          busy_d, busy_q;
    logic          frame_err_d, frame_err_q;
    logic          parity_err_d, parity_err_q;
    logic          overrun_d, overrun_q;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        brk_d        = brk_q;
        fifo_data_d  = fifo_data_q;
        fifo_wr_d    = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // After a framing error the line must go high before a new start is accepted.
                if (rx_s) begin
                    brk_d = 1'b0;
                end else if (!brk_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (^shreg_q) ^ rx_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (fifo_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        fifo_wr_d   = 1'b1;
                        fifo_data_d = shreg_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            brk_q        <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            brk_q        <= brk_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_data  = fifo_data_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
